// File: rtl/ifft_reorder_buffer.sv
// Ping-pong frame buffer: natural-order bins in, bit-reversed gapless bursts out.
// Optional CONJ_OUT_EN build negates (with saturation) the imaginary output.
module ifft_reorder_buffer #(
  parameter int N_LOG2 = 5,
  parameter int W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] in_r,
  input  logic signed [W-1:0] in_i,
  input  logic                in_valid,
  output logic signed [W-1:0] out_r,
  output logic signed [W-1:0] out_i,
  output logic                out_valid,
  output logic                out_sof,
  output logic [N_LOG2-1:0]   out_idx
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = {N_LOG2{1'b1}};

  typedef enum logic {S_IDLE, S_READ} state_t;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int b = 0; b < N_LOG2; b++) r[b] = a[N_LOG2-1-b];
    return r;
  endfunction

  logic [2*W-1:0]    mem_q [2][N];

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] wr_addr_q, wr_addr_d;
  logic              wr_bank_q, wr_bank_d;
  logic [N_LOG2-1:0] rd_addr_q, rd_addr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              issue;

  logic [2*W-1:0]    rd_data_q;
  logic              rd_valid_q, rd_sof_q;
  logic [N_LOG2-1:0] rd_idx_q;

  logic signed [W-1:0] rd_im, out_i_d;
  logic signed [W-1:0] out_r_q, out_i_q;
  logic                out_valid_q, out_sof_q;
  logic [N_LOG2-1:0]   out_idx_q;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    issue     = 1'b0;

    // IDLE issues address 0 on the same edge it leaves, so the first read
    // lands one edge after the full flag becomes visible.
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          issue     = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        issue     = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          state_d           = full_q[rd_bank_q ^ 1'b1] ? S_READ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Write-side set is applied after the read-side clear.
    if (in_valid) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (wr_addr_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) mem_q[wr_bank_q][wr_addr_q] <= {in_r, in_i};
  end

  assign rd_im = rd_data_q[W-1:0];

`ifdef CONJ_OUT_EN
  localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};
  assign out_i_d = (rd_im == MOST_NEG) ? MOST_POS : -rd_im;
`else
  assign out_i_d = rd_im;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      wr_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_sof_q    <= 1'b0;
      rd_idx_q    <= '0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_bank_q   <= wr_bank_d;
      rd_addr_q   <= rd_addr_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      rd_valid_q  <= issue;
      rd_sof_q    <= issue && (rd_addr_q == '0);
      if (issue) begin
        rd_data_q <= mem_q[rd_bank_q][bitrev(rd_addr_q)];
        rd_idx_q  <= bitrev(rd_addr_q);
      end
      out_valid_q <= rd_valid_q;
      out_sof_q   <= rd_sof_q;
      if (rd_valid_q) begin
        out_r_q   <= rd_data_q[2*W-1:W];
        out_i_q   <= out_i_d;
        out_idx_q <= rd_idx_q;
      end
    end
  end

  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_idx   = out_idx_q;

endmodule
